// File: rtl/uart_rx_byte_fifo.sv
// Receive-side byte FIFO behind the UART receiver: one capture per rx_done rising
// edge, show-ahead valid/ready read port, sticky overflow flag for dropped bytes.
module uart_rx_byte_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              clr_overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              done_q;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    logic wr_req;
    logic pop;
    logic wr_acc;
    logic drop;

    // Status flags come from the occupancy counter, never from pointer compare.
    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign rd_valid = ~empty;
    assign rd_data  = mem[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

    always_comb begin
        wr_req     = rx_done & ~done_q;
        pop        = rd_valid & rd_ready;
        wr_acc     = wr_req & (~full | pop);
        drop       = wr_req & ~wr_acc;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + ADDR_W'(1);

        if (wr_acc && !pop)      count_d = count_q + (ADDR_W+1)'(1);
        else if (pop && !wr_acc) count_d = count_q - (ADDR_W+1)'(1);

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop)              overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q     <= rx_done;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= rx_data;
    end

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// Bench for uart_rx_byte_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_rx_byte_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] rx_data = '0;
    logic              rx_done = 1'b0;
    logic              rd_ready = 1'b0;
    logic              clr_overflow = 1'b0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;

    int passes = 0;
    int total  = 0;

    uart_rx_byte_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
        .full(full), .empty(empty), .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFO contents as a queue, rules applied per clock.
    logic [DATA_W-1:0] mq[$];
    bit m_prev = 0;
    bit m_ovf  = 0;
    bit m_req, m_pop, m_drop;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_prev = 0;
            m_ovf  = 0;
        end else begin
            m_req  = rx_done && !m_prev;
            m_pop  = (mq.size() > 0) && rd_ready;
            m_drop = m_req && (mq.size() == DEPTH) && !m_pop;
            if (m_pop) void'(mq.pop_front());
            if (m_req && !m_drop) mq.push_back(rx_data);
            if (m_drop) m_ovf = 1;
            else if (clr_overflow) m_ovf = 0;
            m_prev = rx_done;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("m_count",    32'(count),    32'(mq.size()));
            check("m_empty",    32'(empty),    32'(mq.size() == 0));
            check("m_full",     32'(full),     32'(mq.size() == DEPTH));
            check("m_rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
            check("m_overflow", 32'(overflow), 32'(m_ovf));
            if (mq.size() != 0) check("m_rd_data", 32'(rd_data), 32'(mq[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic byte_edge(input logic [7:0] d);
        rx_data = d;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        check(name, 32'(rd_data), 32'(exp));
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    int exp_next;

    initial begin
        tick();
        tick();
        reset = 1'b0;
        #2;
        check("rst_count",    32'(count),    32'd0);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        tick();

        // Single byte held 3 cycles
        rx_data = 8'hA5;
        rx_done = 1'b1;
        repeat (3) tick();
        rx_done = 1'b0;
        check("single_count", 32'(count),    32'd1);
        check("single_valid", 32'(rd_valid), 32'd1);
        pop_expect("single_data", 8'hA5);
        check("single_empty", 32'(empty), 32'd1);
        check("single_cnt0",  32'(count), 32'd0);

        // Level hold: one write only
        rx_data = 8'h3C;
        rx_done = 1'b1;
        repeat (20) tick();
        rx_done = 1'b0;
        check("hold_count", 32'(count), 32'd1);
        pop_expect("hold_data", 8'h3C);
        check("hold_empty", 32'(empty), 32'd1);

        // Fill, overflow, drain, clear
        for (int i = 0; i < 16; i++) byte_edge(8'(i));
        check("fill_full",  32'(full),  32'd1);
        check("fill_count", 32'(count), 32'd16);
        byte_edge(8'hFF);
        check("ovf_flag",  32'(overflow), 32'd1);
        check("ovf_count", 32'(count),    32'd16);
        for (int i = 0; i < 16; i++) pop_expect("drain_data", 8'(i));
        check("drain_empty", 32'(empty),    32'd1);
        check("ovf_sticky",  32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovf_clear", 32'(overflow), 32'd0);

        // Full with simultaneous pop and write
        for (int i = 0; i < 16; i++) byte_edge(8'(i));
        rx_data  = 8'h55;
        rx_done  = 1'b1;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        rx_done  = 1'b0;
        tick();
        check("fpw_overflow", 32'(overflow), 32'd0);
        check("fpw_count",    32'(count),    32'd16);
        for (int i = 1; i < 16; i++) pop_expect("fpw_data", 8'(i));
        pop_expect("fpw_last", 8'h55);
        check("fpw_empty", 32'(empty), 32'd1);

        // Wrap-around with interleaved pops
        exp_next = 8'h10;
        for (int i = 0; i < 40; i++) begin
            rx_data = 8'(8'h10 + i);
            rx_done = 1'b1;
            if (i >= 3) begin
                check("wrap_data", 32'(rd_data), 32'(exp_next));
                exp_next++;
                rd_ready = 1'b1;
            end
            tick();
            rx_done  = 1'b0;
            rd_ready = 1'b0;
            if (count > 5) check("wrap_bound", 32'(count), 32'd5);
            tick();
        end
        while (exp_next <= 8'h37) begin
            pop_expect("wrap_tail", 8'(exp_next));
            exp_next++;
        end
        check("wrap_empty",    32'(empty),    32'd1);
        check("wrap_overflow", 32'(overflow), 32'd0);

        // Reset mid-operation
        for (int i = 0; i < 7; i++) byte_edge(8'(8'h60 + i));
        check("pre_rst_count", 32'(count), 32'd7);
        #2;
        reset   = 1'b1;
        rx_data = 8'h81;
        rx_done = 1'b1;
        #1;
        check("async_count", 32'(count),    32'd0);
        check("async_empty", 32'(empty),    32'd1);
        check("async_valid", 32'(rd_valid), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        rx_done = 1'b0;
        check("post_rst_count", 32'(count),    32'd1);
        check("post_rst_valid", 32'(rd_valid), 32'd1);
        pop_expect("post_rst_data", 8'h81);
        check("post_rst_empty", 32'(empty), 32'd1);
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte_fifo.md
Name: uart_rx_byte_fifo

Overview:
- Receive-side buffer sitting directly downstream of the UART receiver.
- Captures each completed byte on the rising edge of the receiver's `done` level and stores it in a circular FIFO.
- Presents bytes to the consumer (CPU/bus/display logic) over a show-ahead valid/ready interface.
- Flags bytes lost because the FIFO was full.

Parameters:
- DATA_W, 8, width of one received byte.
- DEPTH, 16, number of FIFO entries; must be a power of two, at least 2.
- ADDR_W, 4, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  DATA_W  byte from the receiver; stable while rx_done is high.
- rx_done  input  1  receiver frame-complete level; stays high until the next start bit.
- rd_ready  input  1  consumer accepts the current head byte this cycle.
- rd_valid  output  1  head byte available (equals !empty).
- rd_data  output  DATA_W  head byte, combinational from memory at rd_ptr.
- count  output  ADDR_W+1  number of stored bytes, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: a byte was dropped.
- clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Clock and reset: clock clk; reset is asynchronous, active-high.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - empty = 1, full = 0, rd_valid = 0, overflow = 0.
  - done_d (edge-detect register) = 0.
  - Memory is not reset; rd_data is don't-care while rd_valid = 0.
- Capture:
  - done_d <= rx_done every cycle.
  - wr_req = rx_done & ~done_d: one request per rx_done rising edge, however long rx_done stays high.
  - rx_data is written at the same edge where rx_done is first sampled high.
  - The byte is visible on rd_data, with rd_valid = 1, immediately after that edge (0-cycle added latency beyond the edge).
- Pop: pop = rd_valid & rd_ready. At the edge, rd_ptr increments and the next head appears on rd_data after the edge.
- Write accept: wr_acc = wr_req & (!full | pop).
  - A write into a full FIFO is accepted when a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow <= 1.
- Count update:
  - wr_acc & !pop → count+1.
  - pop & !wr_acc → count-1.
  - Both or neither → unchanged.
- Empty with simultaneous write: no bypass. rd_valid is 0 that cycle, so no pop; the byte appears the next cycle.
- Pointers wrap modulo DEPTH (natural ADDR_W-bit rollover). full/empty derive from count, not from pointer compare.
- Overflow is sticky until clr_overflow.
  - If clr_overflow and a new drop occur in the same cycle, set wins (overflow stays 1).
  - Dropped bytes never alter pointers, count or memory.
- rd_ready while empty has no effect; pointers never move past the write pointer.
- Reset mid-operation:
  - All contents are discarded, outputs return to reset values, done_d is cleared.
  - If rx_done is still high when reset releases, its level produces one capture at the first clock.
- No combinational path from rd_ready to rd_valid or rd_data.

Test Plan:
- Single byte: after reset, pulse rx_done high 3 cycles with rx_data=8'hA5 → exactly one write; rd_valid=1, rd_data=A5, count=1. Assert rd_ready 1 cycle → empty=1, count=0.
- Level hold: hold rx_done high 20 cycles with rx_data=8'h3C → count stays 1 and no duplicate write.
- Fill and overflow: 16 rising edges with bytes 0x00..0x0F → full=1, count=16. 17th edge with 0xFF → dropped, overflow=1, count=16. Drain → reads 0x00..0x0F in order, then empty=1. Overflow stays 1 until clr_overflow, then 0.
- Full with simultaneous pop and write: full FIFO holding 0x00..0x0F; rd_ready=1 at the same edge as a new 0x55 edge → no overflow, count=16. Drain order 0x01..0x0F, 0x55.
- Wrap-around: write/read 40 bytes (0x10..0x37) with interleaved pops, keeping count ≤ 5 → all bytes read in order, pointers wrap twice, no overflow.
- Reset mid-operation: with 7 bytes stored, assert reset asynchronously between clock edges → count=0, empty=1, rd_valid=0 immediately. After release, a new byte 0x81 reads back correctly as the first entry.
